// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the multiplexed 7-segment display blocks.
// Segment bit order is {dp,g,f,e,d,c,b,a}, active low.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  // Index is the hex digit value; entries are {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] HEX_PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational 4-bit to 7-segment active-low decoder (full hex, b and d lower case).
// The output is {g,f,e,d,c,b,a}.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_PAT[hex];
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed common-anode 7-segment driver.
// Provides frame-coherent input latching, leading-zero blanking, per-digit blink and anode dead time.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int FREQ         = 50_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int NDIG         = 4,
  parameter int DEAD_CYC     = 2,
  parameter int BLINK_FRAMES = 128
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              blank_lz,
  input  logic [NDIG-1:0]   blink,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame
);

  localparam int DIV = FREQ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = $clog2(NDIG);
  localparam int DW  = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [DW-1:0]     dead;
  logic [BW-1:0]     bcnt;
  logic              phase;
  logic [4*NDIG-1:0] sh_digits;
  logic [NDIG-1:0]   sh_dp;
  logic              sh_blz;
  logic [NDIG-1:0]   sh_blink;

  logic              tick;
  logic              frame_edge;
  logic [IW-1:0]     next_idx;
  logic [4*NDIG-1:0] eff_digits;
  logic [NDIG-1:0]   eff_dp;
  logic              eff_blz;
  logic [NDIG-1:0]   eff_blink;
  logic [NDIG-1:0]   lz;
  logic              all_zero;
  logic [3:0]        cur_hex;
  logic              cur_dp;
  logic              cur_blink;
  logic              cur_lz;
  logic [6:0]        dec_out;
  seg_t              seg_next;

  function automatic logic [NDIG-1:0] an_for(input logic [IW-1:0] i);
    an_for    = '1;
    an_for[i] = 1'b0;
  endfunction

  always_comb begin
    tick       = (cnt == CW'(DIV - 1));
    frame_edge = tick && (idx == IW'(NDIG - 1));
    next_idx   = (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
  end

  // The frame-start slot is decoded from the values being latched on that same edge.
  always_comb begin
    eff_digits = frame_edge ? digits   : sh_digits;
    eff_dp     = frame_edge ? dp_in    : sh_dp;
    eff_blz    = frame_edge ? blank_lz : sh_blz;
    eff_blink  = frame_edge ? blink    : sh_blink;
  end

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    lz       = '0;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      all_zero = all_zero && (eff_digits[4*(NDIG-1-i) +: 4] == 4'd0);
      if (NDIG - 1 - i != 0) lz[NDIG-1-i] = eff_blz && all_zero;
    end
  end

  always_comb begin
    cur_hex   = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (IW'(i) == next_idx) begin
        cur_hex   = eff_digits[4*i +: 4];
        cur_dp    = eff_dp[i];
        cur_blink = eff_blink[i];
        cur_lz    = lz[i];
      end
    end
  end

  seg7_hex_dec u_dec (
    .hex (cur_hex),
    .seg (dec_out)
  );

  always_comb begin
    if (cur_blink && phase)  seg_next = SEG_BLANK;
    else if (cur_lz)         seg_next = SEG_BLANK;
    else                     seg_next = {~cur_dp, dec_out};
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt       <= '0;
      idx       <= IW'(NDIG - 1);
      dead      <= '0;
      bcnt      <= '0;
      phase     <= 1'b0;
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blz    <= 1'b0;
      sh_blink  <= '0;
      seg       <= SEG_BLANK;
      an        <= '1;
      frame     <= 1'b0;
    end else begin
      frame <= frame_edge;
      cnt   <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx  <= next_idx;
        seg  <= seg_next;
        dead <= DW'(DEAD_CYC);
        an   <= (DEAD_CYC == 0) ? an_for(next_idx) : '1;
        if (frame_edge) begin
          sh_digits <= digits;
          sh_dp     <= dp_in;
          sh_blz    <= blank_lz;
          sh_blink  <= blink;
          if (bcnt == BW'(BLINK_FRAMES - 1)) begin
            bcnt  <= '0;
            phase <= ~phase;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
      end else if (dead != '0) begin
        dead <= dead - 1'b1;
        if (dead == DW'(1)) an <= an_for(idx);
      end
    end
  end

endmodule
